cursor_draw_controller: RTL
===========================

// Module: cursor_draw_controller
// PURPOSE
//  Sequences cursor moves on the LT24 240x320 display: converts the four user keys into
//  single-step and auto-repeat move commands, keeps the cursor origin, and drives the LT24
//  pixel-write interface to erase the old cursor pixel and draw the new one. Sits between
//  the board key inputs and the LT24 display driver.
// PARAMETERS
//  WIDTH          240          display columns; x range 0..WIDTH-1
//  HEIGHT         320          display rows; y range 0..HEIGHT-1
//  REPEAT_DELAY   25000000     clocks a key is held before auto-repeat starts
//  REPEAT_PERIOD  5000000      clocks between auto-repeat steps
//  FG_COLOUR      16'hFFFF     RGB565 cursor colour
//  BG_COLOUR      16'h0000     RGB565 erase colour
// PORTS
//  clock       in   1   system clock
//  reset       in   1   asynchronous, active-low reset
//  keys        in   4   active-high keys: [0] y+, [1] y-, [2] x+, [3] x-; asynchronous to clock
//  pixelReady  in   1   LT24 driver accepts the current write this cycle
//  pixelWrite  out  1   write request; held until accepted
//  xAddr       out  8   pixel column for the write
//  yAddr       out  9   pixel row for the write
//  pixelData   out  16  RGB565 data for the write
//  xorigin     out  8   current cursor column
//  yorigin     out  9   current cursor row
//  busy        out  1   high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset (reset low): pixelWrite=0, xAddr=0, yAddr=0, pixelData=0, xorigin=0, yorigin=0,
//   busy=1, FSM=INIT, repeat counters=0, pending cleared. Applies immediately, mid-write too.
//  Key path, per key: 2-flop synchroniser, then rise-edge detect. A step pulse appears exactly
//   3 clocks after a stable raw rise. If the key is still held REPEAT_DELAY clocks after that
//   pulse, a further pulse appears then, and every REPEAT_PERIOD clocks after that until release.
//   Release clears the counter.
//  Simultaneous step pulses: lowest key index wins; the others are dropped.
//  Move: new = origin +/- 1. A step that would leave 0..WIDTH-1 / 0..HEIGHT-1 is dropped
//   entirely: no origin change and no write. Arithmetic is done one bit wider, then compared.
//  FSM states:
//   INIT   -> drive a write of FG_COLOUR at (0,0); on accept -> IDLE
//   IDLE   -> busy=0; on a legal step (or a valid pending step) latch the new origin target -> ERASE
//   ERASE  -> write BG_COLOUR at the old origin; on accept, update xorigin/yorigin to the
//             target -> DRAW
//   DRAW   -> write FG_COLOUR at the new origin; on accept -> IDLE
//  Handshake: a transfer occurs only in a cycle with pixelWrite&&pixelReady. xAddr, yAddr and
//   pixelData are registered and stay stable while pixelWrite=1. pixelWrite deasserts in the
//   cycle after the accept, unless the next state issues a write. ERASE->DRAW keeps
//   pixelWrite=1 and updates addr/data in the cycle after the accept.
//  Pending: a legal step arriving while busy=1 is stored in a one-deep pending register, and the
//   first one wins. Later steps are dropped until the pending step is consumed in IDLE. The
//   pending step is re-checked against the boundaries using the origin current at the time it
//   is consumed.
//  Minimum move latency, with pixelReady tied high: key raw rise -> ERASE write at clock 4
//   -> DRAW write at clock 5 -> IDLE at clock 6.
// STRUCTURE
//  Shared package cursor_pkg: FSM state localparams (INIT, IDLE, ERASE, DRAW), key direction
//   codes, WIDTH/HEIGHT defaults, colour constants.
//  Sub-module key_repeat, instanced 4x: synchroniser, edge detect and repeat counter; output is
//   a 1-clock step pulse. Parameters: REPEAT_DELAY, REPEAT_PERIOD.
//  Top level: priority encoder, boundary check, pending register, FSM and output registers.
// TESTING  (REPEAT_DELAY=8, REPEAT_PERIOD=4 for simulation)
//  1 Release reset, pixelReady=1 -> one write at (0,0) data FFFF, then busy=0, origin (0,0).
//  2 Pulse keys[0] for 2 clocks -> writes (0,0)=0000 then (0,1)=FFFF; yorigin=1.
//  3 At origin (0,0) press keys[1] and keys[3] -> no write, origin unchanged. At x=239 press
//    keys[2] -> no write.
//  4 Hold keys[2] for 30 clocks -> steps at t=3,11,15,19,23,27; xorigin advances by 6.
//  5 Hold pixelReady=0 for 10 clocks during ERASE -> pixelWrite, xAddr, yAddr and pixelData
//    stay stable; pulse keys[0] then keys[2] meanwhile -> only the y+ step is applied after DRAW.
//  6 Assert reset during DRAW with pixelWrite=1 -> pixelWrite=0 the same cycle, origin (0,0);
//    after release -> INIT write at (0,0) again.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared types and constants for the LT24 cursor draw controller.
// The single move helper is used for both live and pending steps.
package cursor_pkg;

  localparam int unsigned DEF_WIDTH  = 240;
  localparam int unsigned DEF_HEIGHT = 320;
  localparam logic [15:0] DEF_FG     = 16'hFFFF;
  localparam logic [15:0] DEF_BG     = 16'h0000;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ERASE,
    ST_DRAW
  } state_t;

  // Direction codes equal the key index, so the priority encoder can cast directly.
  typedef enum logic [1:0] {
    DIR_Y_INC = 2'd0,
    DIR_Y_DEC = 2'd1,
    DIR_X_INC = 2'd2,
    DIR_X_DEC = 2'd3
  } dir_t;

  typedef struct packed {
    logic       legal;
    logic [7:0] x;
    logic [8:0] y;
  } move_t;

  // Works one bit wider than the origin, so stepping below zero wraps to a large
  // value and fails the same upper-bound compare as stepping past the edge.
  function automatic move_t apply_move(input dir_t        dir,
                                       input logic [7:0]  x,
                                       input logic [8:0]  y,
                                       input int unsigned width,
                                       input int unsigned height);
    logic [8:0] nx;
    logic [9:0] ny;
    move_t      m;
    nx = {1'b0, x};
    ny = {1'b0, y};
    case (dir)
      DIR_Y_INC: ny = ny + 10'd1;
      DIR_Y_DEC: ny = ny - 10'd1;
      DIR_X_INC: nx = nx + 9'd1;
      DIR_X_DEC: nx = nx - 9'd1;
      default:   ;
    endcase
    m.legal = (nx < 9'(width)) && (ny < 10'(height));
    m.x     = nx[7:0];
    m.y     = ny[8:0];
    return m;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// One key: two-flop synchroniser, rise detect and hold-to-repeat counter.
// Emits a one-clock step pulse on press, after REPEAT_DELAY, then every REPEAT_PERIOD.
module key_repeat #(
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic step
);

  localparam int unsigned MAX_COUNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1);

  logic             sync1;
  logic             sync2;
  logic             sync2_d;
  logic             repeating;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;

  assign limit = repeating ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);

  // count holds the clocks elapsed since the last pulse, so a pulse fires when it
  // reaches the current limit and restarts at one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync2_d   <= 1'b0;
      repeating <= 1'b0;
      count     <= '0;
      step      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns sync1/sync2/sync2_d into a real shift chain.
      sync1   <= key;
      sync2   <= sync1;
      sync2_d <= sync2;
      step    <= 1'b0;
      if (!sync2) begin
        count     <= '0;
        repeating <= 1'b0;
      end else if (!sync2_d) begin
        step      <= 1'b1;
        count     <= CNT_W'(1);
        repeating <= 1'b0;
      end else if (count == limit) begin
        step      <= 1'b1;
        count     <= CNT_W'(1);
        repeating <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_draw_controller.sv
// Turns key steps into cursor moves and drives the LT24 pixel-write handshake:
// erase the old cursor pixel, then draw the new one.
module cursor_draw_controller
  import cursor_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned HEIGHT        = DEF_HEIGHT,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter logic [15:0] FG_COLOUR     = DEF_FG,
  parameter logic [15:0] BG_COLOUR     = DEF_BG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  keys,
  input  logic        pixelReady,
  output logic        pixelWrite,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic [7:0]  xorigin,
  output logic [8:0]  yorigin,
  output logic        busy
);

  logic [3:0] step_vec;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_key (
      .clock(clock),
      .reset(reset),
      .key  (keys[g]),
      .step (step_vec[g])
    );
  end

  logic  step_valid;
  dir_t  step_dir;
  move_t step_move;

  // Lowest key index wins: the loop runs downward so it assigns last.
  always_comb begin
    step_valid = 1'b0;
    step_dir   = DIR_Y_INC;
    for (int i = 3; i >= 0; i--) begin
      if (step_vec[i]) begin
        step_valid = 1'b1;
        step_dir   = dir_t'(2'(i));
      end
    end
  end

  state_t      state, state_n;
  logic        write_n;
  logic [7:0]  x_addr_n;
  logic [8:0]  y_addr_n;
  logic [15:0] data_n;
  logic [7:0]  xorigin_n, target_x, target_x_n;
  logic [8:0]  yorigin_n, target_y, target_y_n;
  logic        pend_valid, pend_valid_n;
  dir_t        pend_dir, pend_dir_n;
  move_t       pend_move;
  move_t       launch;
  logic        launch_en;
  logic        accept;

  assign step_move = apply_move(step_dir, xorigin, yorigin, WIDTH, HEIGHT);
  assign pend_move = apply_move(pend_dir, xorigin, yorigin, WIDTH, HEIGHT);
  assign accept    = pixelWrite && pixelReady;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    // NOTE: every variable gets a default before the case; a path that skipped an
    // assignment would otherwise infer a latch.
    state_n      = state;
    write_n      = pixelWrite;
    x_addr_n     = xAddr;
    y_addr_n     = yAddr;
    data_n       = pixelData;
    xorigin_n    = xorigin;
    yorigin_n    = yorigin;
    target_x_n   = target_x;
    target_y_n   = target_y;
    pend_valid_n = pend_valid;
    pend_dir_n   = pend_dir;
    launch       = step_move;
    launch_en    = 1'b0;

    case (state)
      ST_INIT: begin
        write_n  = 1'b1;
        x_addr_n = '0;
        y_addr_n = '0;
        data_n   = FG_COLOUR;
        if (accept) begin
          state_n = ST_IDLE;
          write_n = 1'b0;
        end
      end
      ST_IDLE: begin
        write_n = 1'b0;
        // A stored step is re-validated against today's origin; a step arriving in
        // the same cycle as the pending one is dropped.
        if (pend_valid) begin
          pend_valid_n = 1'b0;
          launch       = pend_move;
          launch_en    = pend_move.legal;
        end else if (step_valid && step_move.legal) begin
          launch_en = 1'b1;
        end
      end
      ST_ERASE: begin
        if (accept) begin
          xorigin_n = target_x;
          yorigin_n = target_y;
          state_n   = ST_DRAW;
          write_n   = 1'b1;
          x_addr_n  = target_x;
          y_addr_n  = target_y;
          data_n    = FG_COLOUR;
        end
      end
      ST_DRAW: begin
        if (accept) begin
          state_n = ST_IDLE;
          write_n = 1'b0;
        end
      end
      default: state_n = ST_INIT;
    endcase

    if (launch_en) begin
      target_x_n = launch.x;
      target_y_n = launch.y;
      state_n    = ST_ERASE;
      write_n    = 1'b1;
      x_addr_n   = xorigin;
      y_addr_n   = yorigin;
      data_n     = BG_COLOUR;
    end

    if (state != ST_IDLE && step_valid && step_move.legal && !pend_valid) begin
      pend_valid_n = 1'b1;
      pend_dir_n   = step_dir;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      pixelWrite <= 1'b0;
      xAddr      <= '0;
      yAddr      <= '0;
      pixelData  <= '0;
      xorigin    <= '0;
      yorigin    <= '0;
      target_x   <= '0;
      target_y   <= '0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_Y_INC;
    end else begin
      state      <= state_n;
      pixelWrite <= write_n;
      xAddr      <= x_addr_n;
      yAddr      <= y_addr_n;
      pixelData  <= data_n;
      xorigin    <= xorigin_n;
      yorigin    <= yorigin_n;
      target_x   <= target_x_n;
      target_y   <= target_y_n;
      pend_valid <= pend_valid_n;
      pend_dir   <= pend_dir_n;
    end
  end

endmodule
